// File: rtl/stopwatch_counter_if.sv
// Control and display bundle for stopwatch_counter: master drives the pulses,
// slave (the counter) returns the BCD digits and status flags.
interface stopwatch_counter_if;
  logic       tick;
  logic       count_enable;
  logic       clear_in;
  logic       lap_in;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       wrap;
  logic       frozen;

  modport master (
    output tick, count_enable, clear_in, lap_in,
    input  min_tens, min_ones, sec_tens, sec_ones, wrap, frozen
  );

  modport slave (
    input  tick, count_enable, clear_in, lap_in,
    output min_tens, min_ones, sec_tens, sec_ones, wrap, frozen
  );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch, 00:00-59:59, with a one-cycle wrap pulse.
// Optional lap-hold snapshot display is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_counter (
  input  logic                 clk,
  input  logic                 reset,
  stopwatch_counter_if.slave   sw
);

  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       wrap_q, wrap_d;
  logic       advance;

  assign advance = sw.tick && sw.count_enable;

  // Ripple carry: each digit only moves when all lower digits are at their maximum.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    if (sw.clear_in) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if (advance) begin
      if (sec_ones_q != 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q != 4'd5) begin
          sec_tens_d = sec_tens_q + 4'd1;
        end else begin
          sec_tens_d = 4'd0;
          if (min_ones_q != 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = 4'd0;
            if (min_tens_q != 4'd5) begin
              min_tens_d = min_tens_q + 4'd1;
            end else begin
              min_tens_d = 4'd0;
              wrap_d     = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      wrap_q     <= 1'b0;
    end else begin
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      wrap_q     <= wrap_d;
    end
  end

  assign sw.wrap = wrap_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic [15:0] snap_q, snap_d;
  logic        frozen_q, frozen_d;
  logic [15:0] disp_q, disp_d;

  // The display register is loaded from next-state values so it stays in step
  // with the live count and freeze flag while still being a plain flop output.
  always_comb begin
    snap_d   = snap_q;
    frozen_d = frozen_q;
    if (sw.clear_in) begin
      snap_d   = 16'd0;
      frozen_d = 1'b0;
    end else if (sw.lap_in) begin
      if (!frozen_q) begin
        snap_d   = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
        frozen_d = 1'b1;
      end else begin
        frozen_d = 1'b0;
      end
    end
    disp_d = frozen_d ? snap_d : {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q   <= 16'd0;
      frozen_q <= 1'b0;
      disp_q   <= 16'd0;
    end else begin
      snap_q   <= snap_d;
      frozen_q <= frozen_d;
      disp_q   <= disp_d;
    end
  end

  assign sw.frozen = frozen_q;
  assign {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones} = disp_q;
`else
  logic unused_lap;
  assign unused_lap = sw.lap_in;

  assign sw.frozen   = 1'b0;
  assign sw.min_tens = min_tens_q;
  assign sw.min_ones = min_ones_q;
  assign sw.sec_tens = sec_tens_q;
  assign sw.sec_ones = sec_ones_q;
`endif

endmodule
